// File: rtl/hysteresis_counter_pkg.sv
// Shared constants and parameter-legality check for hysteresis counters.
// The macro HYSTERESIS_COUNTER_CHECK_PARAMS rejects illegal parameter sets at elaboration.
`ifndef HYSTERESIS_COUNTER_PKG_SV
`define HYSTERESIS_COUNTER_PKG_SV

`define HYSTERESIS_COUNTER_CHECK_PARAMS(RNG, COERC, RSTV, DPTH) \
    if (!((RNG) >= 2 && ((RNG) % 2) == 0 && (COERC) >= 0 && (COERC) <= (RNG) / 2 - 1 && \
          (RSTV) >= 0 && (RSTV) < (RNG) && (DPTH) >= 2)) begin : g_illegal_params \
        $error("hysteresis counter: illegal parameter combination"); \
    end

package hysteresis_counter_pkg;

    function automatic int hc_max(input int range);
        return range - 1;
    endfunction

    function automatic int hc_half_low(input int range);
        return range / 2 - 1;
    endfunction

    function automatic int hc_half_high(input int range);
        return range / 2;
    endfunction

    function automatic int hc_jump_low(input int range, input int coercivity);
        return range / 2 - 1 - coercivity;
    endfunction

    function automatic int hc_jump_high(input int range, input int coercivity);
        return range / 2 + coercivity;
    endfunction

endpackage

`endif

// File: rtl/hysteresis_counter_step.sv
// Combinational next-value function of one hysteresis saturating counter.
// Increment and decrement together leave the value unchanged.
module hysteresis_counter_step
    import hysteresis_counter_pkg::*;
#(
    parameter int RANGE      = 4,
    parameter int RANGE_LOG2 = $clog2(RANGE),
    parameter int COERCIVITY = 1
) (
    input  logic [RANGE_LOG2-1:0] value,
    input  logic                  increment,
    input  logic                  decrement,
    output logic [RANGE_LOG2-1:0] next_value
);

    `HYSTERESIS_COUNTER_CHECK_PARAMS(RANGE, COERCIVITY, 0, 2)

    localparam logic [RANGE_LOG2-1:0] MAX_V       = RANGE_LOG2'(hc_max(RANGE));
    localparam logic [RANGE_LOG2-1:0] HALF_LOW_V  = RANGE_LOG2'(hc_half_low(RANGE));
    localparam logic [RANGE_LOG2-1:0] HALF_HIGH_V = RANGE_LOG2'(hc_half_high(RANGE));
    localparam logic [RANGE_LOG2-1:0] JUMP_LOW_V  = RANGE_LOG2'(hc_jump_low(RANGE, COERCIVITY));
    localparam logic [RANGE_LOG2-1:0] JUMP_HIGH_V = RANGE_LOG2'(hc_jump_high(RANGE, COERCIVITY));
    localparam logic [RANGE_LOG2-1:0] ONE_V       = RANGE_LOG2'(1);

    // Saturation is tested before +1/-1, so the arithmetic can never wrap.
    always_comb begin
        next_value = value;
        if (increment && !decrement) begin
            if (value == MAX_V)
                next_value = MAX_V;
            else if (value == HALF_LOW_V)
                next_value = JUMP_HIGH_V;
            else
                next_value = value + ONE_V;
        end else if (decrement && !increment) begin
            if (value == '0)
                next_value = '0;
            else if (value == HALF_HIGH_V)
                next_value = JUMP_LOW_V;
            else
                next_value = value - ONE_V;
        end
    end

endmodule

// File: rtl/hysteresis_counter_table.sv
// Table of DEPTH hysteresis saturating counters with one read and one update port.
// Define HYSTERESIS_COUNTER_TABLE_BYPASS_EN to forward same-cycle updates/flushes to the read port.
module hysteresis_counter_table
    import hysteresis_counter_pkg::*;
#(
    parameter int RANGE       = 4,
    parameter int RANGE_LOG2  = $clog2(RANGE),
    parameter int RESET_VALUE = 0,
    parameter int COERCIVITY  = 1,
    parameter int DEPTH       = 16,
    parameter int DEPTH_LOG2  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic [DEPTH_LOG2-1:0] update_index,
    input  logic                  update_increment,
    input  logic                  update_decrement,
    input  logic [DEPTH_LOG2-1:0] read_index,
    output logic [RANGE_LOG2-1:0] read_count,
    output logic                  read_high
);

    `HYSTERESIS_COUNTER_CHECK_PARAMS(RANGE, COERCIVITY, RESET_VALUE, DEPTH)

    localparam logic [RANGE_LOG2-1:0] RESET_V     = RANGE_LOG2'(RESET_VALUE);
    localparam logic [RANGE_LOG2-1:0] HALF_HIGH_V = RANGE_LOG2'(hc_half_high(RANGE));
    localparam logic [DEPTH_LOG2:0]   DEPTH_V     = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [RANGE_LOG2-1:0] entries [DEPTH];
    logic                  update_in_range;
    logic                  read_in_range;
    logic [RANGE_LOG2-1:0] update_current;
    logic [RANGE_LOG2-1:0] update_next;
    logic [RANGE_LOG2-1:0] read_stored;

    assign update_in_range = ({1'b0, update_index} < DEPTH_V);
    assign read_in_range   = ({1'b0, read_index} < DEPTH_V);
    assign update_current  = update_in_range ? entries[update_index] : '0;
    assign read_stored     = read_in_range ? entries[read_index] : '0;

    hysteresis_counter_step #(
        .RANGE      (RANGE),
        .RANGE_LOG2 (RANGE_LOG2),
        .COERCIVITY (COERCIVITY)
    ) u_update_step (
        .value      (update_current),
        .increment  (update_increment),
        .decrement  (update_decrement),
        .next_value (update_next)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                entries[i] <= RESET_V;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                entries[i] <= RESET_V;
        end else if (update_in_range) begin
            entries[update_index] <= update_next;
        end
    end

`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
    logic                  read_hit;
    logic [RANGE_LOG2-1:0] read_forward;

    assign read_hit = update_in_range && (update_index == read_index);

    // Second step instance evaluates the read entry as if the pending update had landed.
    hysteresis_counter_step #(
        .RANGE      (RANGE),
        .RANGE_LOG2 (RANGE_LOG2),
        .COERCIVITY (COERCIVITY)
    ) u_bypass_step (
        .value      (read_stored),
        .increment  (update_increment && read_hit),
        .decrement  (update_decrement && read_hit),
        .next_value (read_forward)
    );

    always_comb begin
        read_count = read_forward;
        if (!read_in_range)
            read_count = '0;
        else if (flush)
            read_count = RESET_V;
    end
`else
    assign read_count = read_stored;
`endif

    assign read_high = (read_count >= HALF_HIGH_V);

endmodule

// File: tb/tb_hysteresis_counter_table.sv
// Self-checking bench for hysteresis_counter_table at default parameters.
module tb_hysteresis_counter_table;

    logic       clock = 1'b0;
    logic       resetn;
    logic       flush;
    logic [3:0] update_index;
    logic       update_increment;
    logic       update_decrement;
    logic [3:0] read_index;
    logic [1:0] read_count;
    logic       read_high;

    hysteresis_counter_table dut (
        .clock            (clock),
        .resetn           (resetn),
        .flush            (flush),
        .update_index     (update_index),
        .update_increment (update_increment),
        .update_decrement (update_decrement),
        .read_index       (read_index),
        .read_count       (read_count),
        .read_high        (read_high)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic       flush;
        logic [3:0] uidx;
        logic       inc;
        logic       dec;
        logic [3:0] ridx;
        logic [1:0] exp_count;
        logic       exp_high;
    } vec_t;

    typedef struct packed {
        logic [1:0] count;
        logic       high;
    } exp_t;

    vec_t vecs [$];
    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic f, input logic [3:0] ui, input logic inc,
                                input logic dec, input logic [3:0] ri,
                                input logic [1:0] ec, input logic eh);
        vec_t v;
        v = '{flush: f, uidx: ui, inc: inc, dec: dec, ridx: ri, exp_count: ec, exp_high: eh};
        vecs.push_back(v);
    endfunction

    task automatic expect_out(input logic [1:0] c, input logic h);
        exp_t e;
        e.count = c;
        e.high  = h;
        sb.push_back(e);
    endtask

    task automatic check(input string name);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, read_count=%0d read_high=%0b", name, read_count, read_high);
            return;
        end
        e = sb.pop_front();
        if (read_count !== e.count || read_high !== e.high) begin
            bad++;
            $display("FAIL %s: read_count=%0d read_high=%0b, expected read_count=%0d read_high=%0b",
                     name, read_count, read_high, e.count, e.high);
        end
    endtask

    task automatic idle();
        flush            = 1'b0;
        update_increment = 1'b0;
        update_decrement = 1'b0;
    endtask

    // Drive one row, let the edge land, then quiesce the update so both builds read stored state.
    task automatic apply(input vec_t v, input string name);
        flush            = v.flush;
        update_index     = v.uidx;
        update_increment = v.inc;
        update_decrement = v.dec;
        read_index       = v.ridx;
        expect_out(v.exp_count, v.exp_high);
        @(posedge clock);
        #1 idle();
        #1 check(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        update_index = '0;
        read_index   = '0;
        idle();

        // Reset sweep, then release and sweep again
        for (int i = 0; i < 16; i++) begin
            read_index = 4'(i);
            expect_out(2'd0, 1'b0);
            #1 check($sformatf("reset_sweep%0d", i));
        end
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #2;
        for (int i = 0; i < 16; i++) begin
            read_index = 4'(i);
            expect_out(2'd0, 1'b0);
            #1 check($sformatf("post_reset%0d", i));
        end

        //   flush uidx inc dec ridx count high
        add(0, 3, 1, 0, 3, 2'd1, 0);
        add(0, 3, 1, 0, 3, 2'd3, 1);
        add(0, 3, 1, 0, 3, 2'd3, 1);
        add(0, 3, 1, 0, 3, 2'd3, 1);
        add(0, 0, 0, 0, 4, 2'd0, 0);
        add(0, 3, 0, 1, 3, 2'd2, 1);
        add(0, 3, 0, 1, 3, 2'd0, 0);
        add(0, 3, 0, 1, 3, 2'd0, 0);
        add(0, 3, 0, 1, 3, 2'd0, 0);
        add(0, 5, 1, 0, 5, 2'd1, 0);
        add(0, 5, 1, 1, 5, 2'd1, 0);
        add(0, 5, 1, 0, 5, 2'd3, 1);
        add(0, 5, 1, 1, 5, 2'd3, 1);
        add(0, 5, 0, 0, 5, 2'd3, 1);
        add(0, 2, 1, 0, 2, 2'd1, 0);
        add(0, 7, 1, 0, 7, 2'd1, 0);
        add(0, 7, 1, 0, 7, 2'd3, 1);
        add(0, 9, 1, 0, 9, 2'd1, 0);
        add(0, 0, 0, 0, 2, 2'd1, 0);
        add(1, 7, 1, 0, 7, 2'd0, 0);
        add(0, 0, 0, 0, 2, 2'd0, 0);
        add(0, 0, 0, 0, 9, 2'd0, 0);
        add(0, 0, 0, 0, 5, 2'd0, 0);
        add(0, 10, 0, 1, 10, 2'd0, 0);
        add(0, 15, 1, 0, 15, 2'd1, 0);
        add(0, 14, 1, 0, 15, 2'd1, 0);
        add(0, 2, 1, 0, 2, 2'd1, 0);

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("vec%0d", i));

        // Same-cycle read of an entry being incremented (entry 2 holds 1)
        update_index     = 4'd2;
        update_increment = 1'b1;
        read_index       = 4'd2;
`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
        expect_out(2'd3, 1'b1);
`else
        expect_out(2'd1, 1'b0);
`endif
        #1 check("bypass_same_cycle");
        expect_out(2'd3, 1'b1);
        @(posedge clock);
        #1 idle();
        #1 check("bypass_next_cycle");

        // Same-cycle read during flush (entry 2 holds 3)
        flush = 1'b1;
`ifdef HYSTERESIS_COUNTER_TABLE_BYPASS_EN
        expect_out(2'd0, 1'b0);
`else
        expect_out(2'd3, 1'b1);
`endif
        #1 check("flush_same_cycle");
        expect_out(2'd0, 1'b0);
        @(posedge clock);
        #1 idle();
        #1 check("flush_next_cycle");

        // Reset asserted mid-update discards the update (entry 15 holds 1)
        update_index     = 4'd15;
        update_increment = 1'b1;
        read_index       = 4'd15;
        #2 resetn = 1'b0;
        expect_out(2'd0, 1'b0);
        #1 check("async_reset_immediate");
        @(posedge clock);
        expect_out(2'd0, 1'b0);
        #1 check("reset_held_over_edge");
        idle();
        @(negedge clock);
        resetn = 1'b1;
        expect_out(2'd0, 1'b0);
        #1 check("reset_released");
        expect_out(2'd0, 1'b0);
        read_index = 4'd7;
        #1 check("reset_cleared_entry7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
